// File: rtl/seg7_pkg.sv
// Shared types and constants for the counter display path: converter state,
// active-low 7-segment glyphs and scan digit positions.
package seg7_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_e;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_DIR      = 2'd3;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), one bit
// per cycle. `done` pulses on the final iteration with the result on `bcd`.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bin,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [9:0] bcd
);

    conv_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  bin_q, bin_d;
    // Before the last shift at most 7 bits have entered, so the hundreds
    // digit is still a single bit and 9 stored bits are enough.
    logic [8:0]  bcd_q, bcd_d;
    logic [7:0]  corr;
    logic [9:0]  bcd_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            bin_q   <= 8'd0;
            bcd_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
        end
    end

    always_comb begin
        corr = bcd_q[7:0];
        if (bcd_q[3:0] >= 4'd5) corr[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) corr[7:4] = bcd_q[7:4] + 4'd3;
        bcd_shift = {bcd_q[8], corr, bin_q[7]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    bin_d   = bin;
                    bcd_d   = 9'd0;
                    cnt_d   = 3'd7;
                end
            end
            CONV: begin
                bcd_d = bcd_shift[8:0];
                bin_d = {bin_q[6:0], 1'b0};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CONV);
        done = (state_q == CONV) && (cnt_q == 3'd0);
        bcd  = bcd_shift;
    end

endmodule

// File: rtl/seg7_count_display.sv
// Counter value display: change-triggered BCD conversion and a 4-digit
// multiplexed scan (ones, tens, hundreds, direction). SEG7_LEADING_ZERO_BLANK_EN
// blanks leading zeros of the hundreds and tens digits.
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       ud,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       busy
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    logic [7:0]    last_q, last_d;
    logic [1:0]    d2_q, d2_d;
    logic [3:0]    d1_q, d1_d;
    logic [3:0]    d0_q, d0_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic       conv_busy, conv_done, start, tick;
    logic [9:0] conv_bcd;
    logic       blank_hund, blank_tens;

    // Compare against the live value only while idle: changes during a
    // conversion are dropped and the latest value is picked up afterwards.
    assign start = !conv_busy && (value != last_q);
    assign tick  = (ref_q == REF_LAST);
    assign busy  = conv_busy;
    assign an    = an_q;
    assign seg   = seg_q;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .bin   (value),
        .start (start),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign blank_hund = (d2_q == 2'd0);
    assign blank_tens = (d2_q == 2'd0) && (d1_q == 4'd0);
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
`endif

    always_comb begin
        last_d = start ? value : last_q;
        d2_d   = d2_q;
        d1_d   = d1_q;
        d0_d   = d0_q;
        if (conv_done) begin
            d2_d = conv_bcd[9:8];
            d1_d = conv_bcd[7:4];
            d0_d = conv_bcd[3:0];
        end

        ref_d = tick ? '0 : ref_q + RW'(1);
        idx_d = tick ? idx_q + 2'd1 : idx_q;
        an_d  = an_q;
        seg_d = seg_q;
        if (tick) begin
            an_d = ~(4'b0001 << idx_d);
            case (idx_d)
                DIG_ONES:     seg_d = digit_glyph(d0_q);
                DIG_TENS:     seg_d = blank_tens ? SEG_BLANK : digit_glyph(d1_q);
                DIG_HUNDREDS: seg_d = blank_hund ? SEG_BLANK : digit_glyph({2'b00, d2_q});
                default:      seg_d = ud ? SEG_U : SEG_D;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 8'd0;
            d2_q   <= 2'd0;
            d1_q   <= 4'd0;
            d0_q   <= 4'd0;
            ref_q  <= '0;
            idx_q  <= DIG_DIR;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
        end else begin
            last_q <= last_d;
            d2_q   <= d2_d;
            d1_q   <= d1_d;
            d0_q   <= d0_d;
            ref_q  <= ref_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

endmodule
